// File: rtl/toy_pack.sv
// Shared widths and linefill write-buffer entry type for the icache data path.
package toy_pack;

    localparam int ICACHE_INDEX_WIDTH     = 6;
    localparam int ICACHE_DATA_WIDTH      = 32;
    localparam int ICACHE_REQ_TXNID_WIDTH = 4;

    typedef struct packed {
        logic [ICACHE_INDEX_WIDTH-1:0]     index;
        logic                              way;
        logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
        logic [ICACHE_DATA_WIDTH-1:0]      data;
    } icache_wbuf_entry_t;

    // Data RAM address of a buffered line: {index, way}.
    function automatic logic [ICACHE_INDEX_WIDTH:0] wbuf_addr(input icache_wbuf_entry_t e);
        return {e.index, e.way};
    endfunction

endpackage

// File: rtl/icache_linefill_wbuf.sv
// Linefill write buffer: circular FIFO with per-entry valid/address taps so the
// arbiter can detect reads that would hit a line not yet written to the RAM.
module icache_linefill_wbuf
    import toy_pack::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     push,
    input  icache_wbuf_entry_t                       push_entry,
    input  logic                                     pop,
    output icache_wbuf_entry_t                       head,
    output logic                                     full,
    output logic                                     empty,
    output logic [DEPTH-1:0]                         ent_vld,
    output logic [DEPTH-1:0][ICACHE_INDEX_WIDTH:0]   ent_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    icache_wbuf_entry_t mem_q [DEPTH];
    icache_wbuf_entry_t mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Next-state: pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // State registers; line storage is not reset since valid is derived from count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off         = PW'(i) - rd_ptr_q;
        assign ent_vld[i]  = ({1'b0, off} < cnt_q);
        assign ent_addr[i] = wbuf_addr(mem_q[i]);
    end

endmodule

// File: rtl/icache_data_array_arb.sv
// Single-port icache data RAM arbiter between hit reads and buffered linefill
// writes, with starvation bound on writes and read-after-pending-write hazard.
module icache_data_array_arb
    import toy_pack::*;
#(
    parameter int WBUF_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rd_vld,
    output logic                              rd_rdy,
    input  logic [ICACHE_INDEX_WIDTH-1:0]     rd_index,
    input  logic                              rd_way,
    input  logic [ICACHE_REQ_TXNID_WIDTH-1:0] rd_txnid,
    input  logic                              lf_vld,
    output logic                              lf_rdy,
    input  logic [ICACHE_INDEX_WIDTH-1:0]     lf_index,
    input  logic                              lf_way,
    input  logic [ICACHE_REQ_TXNID_WIDTH-1:0] lf_txnid,
    input  logic [ICACHE_DATA_WIDTH-1:0]      lf_data,
    output logic                              ram_en,
    output logic                              ram_wr_en,
    output logic [ICACHE_INDEX_WIDTH:0]       ram_addr,
    output logic [ICACHE_DATA_WIDTH-1:0]      ram_din,
    input  logic [ICACHE_DATA_WIDTH-1:0]      ram_dout,
    output logic                              up_vld,
    output logic [ICACHE_REQ_TXNID_WIDTH-1:0] up_txnid,
    output logic [ICACHE_DATA_WIDTH-1:0]      up_data,
    output logic                              lf_commit,
    output logic [ICACHE_REQ_TXNID_WIDTH-1:0] lf_commit_txnid
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    icache_wbuf_entry_t                          push_entry, head;
    logic                                        push, full, empty;
    logic [WBUF_DEPTH-1:0]                       ent_vld;
    logic [WBUF_DEPTH-1:0][ICACHE_INDEX_WIDTH:0] ent_addr;
    logic                                        hazard, wr_gnt, rd_gnt;

    logic [SW-1:0]                       starve_q, starve_d;
    logic                                up_vld_q, up_vld_d;
    logic                                up_src_wr_q, up_src_wr_d;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0]   up_txnid_q, up_txnid_d;
    logic [ICACHE_DATA_WIDTH-1:0]        up_wdata_q, up_wdata_d;

    assign lf_rdy     = !full;
    assign push       = lf_vld && lf_rdy;
    assign push_entry = '{index: lf_index, way: lf_way, txnid: lf_txnid, data: lf_data};

    icache_linefill_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (wr_gnt),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .ent_vld    (ent_vld),
        .ent_addr   (ent_addr)
    );

    // Grant: drain the buffer when reads are idle, buffer is full, reads have
    // starved it long enough, or the read targets a line still in the buffer.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (ent_vld[i] && ent_addr[i] == {rd_index, rd_way}) hazard = 1'b1;
        end
        wr_gnt = !rst && !empty &&
                 (!rd_vld || full || starve_q == SW'(STARVE_MAX) || hazard);
        rd_gnt = !rst && rd_vld && !wr_gnt;

        starve_d = starve_q;
        if (wr_gnt || empty)                          starve_d = '0;
        else if (rd_gnt && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + SW'(1);

        up_vld_d    = rd_gnt || wr_gnt;
        up_src_wr_d = wr_gnt;
        up_txnid_d  = wr_gnt ? head.txnid : (rd_gnt ? rd_txnid : '0);
        up_wdata_d  = wr_gnt ? head.data : '0;
    end

    // Starvation counter and upstream return pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            up_vld_q    <= 1'b0;
            up_src_wr_q <= 1'b0;
            up_txnid_q  <= '0;
            up_wdata_q  <= '0;
        end else begin
            starve_q    <= starve_d;
            up_vld_q    <= up_vld_d;
            up_src_wr_q <= up_src_wr_d;
            up_txnid_q  <= up_txnid_d;
            up_wdata_q  <= up_wdata_d;
        end
    end

    assign rd_rdy          = rd_gnt;
    assign ram_en          = rd_gnt || wr_gnt;
    assign ram_wr_en       = wr_gnt;
    assign ram_addr        = wr_gnt ? wbuf_addr(head) : (rd_gnt ? {rd_index, rd_way} : '0);
    assign ram_din         = wr_gnt ? head.data : '0;
    assign lf_commit       = wr_gnt;
    assign lf_commit_txnid = wr_gnt ? head.txnid : '0;

    // A written line returns its buffered copy; a read returns the RAM output.
    assign up_vld   = up_vld_q;
    assign up_txnid = up_vld_q ? up_txnid_q : '0;
    assign up_data  = up_vld_q ? (up_src_wr_q ? up_wdata_q : ram_dout) : '0;

endmodule

// File: tb/tb_icache_data_array_arb.sv
// Directed bench for icache_data_array_arb with a simple behavioural data RAM.
module tb_icache_data_array_arb;
    import toy_pack::*;

    localparam int IW = ICACHE_INDEX_WIDTH;
    localparam int DW = ICACHE_DATA_WIDTH;
    localparam int TW = ICACHE_REQ_TXNID_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_vld, rd_rdy, rd_way;
    logic [IW-1:0] rd_index;
    logic [TW-1:0] rd_txnid;
    logic          lf_vld, lf_rdy, lf_way;
    logic [IW-1:0] lf_index;
    logic [TW-1:0] lf_txnid;
    logic [DW-1:0] lf_data;
    logic          ram_en, ram_wr_en;
    logic [IW:0]   ram_addr;
    logic [DW-1:0] ram_din, ram_dout;
    logic          up_vld;
    logic [TW-1:0] up_txnid;
    logic [DW-1:0] up_data;
    logic          lf_commit;
    logic [TW-1:0] lf_commit_txnid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icache_data_array_arb #(.WBUF_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_index(rd_index), .rd_way(rd_way), .rd_txnid(rd_txnid),
        .lf_vld(lf_vld), .lf_rdy(lf_rdy), .lf_index(lf_index), .lf_way(lf_way), .lf_txnid(lf_txnid),
        .lf_data(lf_data),
        .ram_en(ram_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .up_vld(up_vld), .up_txnid(up_txnid), .up_data(up_data),
        .lf_commit(lf_commit), .lf_commit_txnid(lf_commit_txnid)
    );

    // Data RAM model: unwritten locations read as 0xA0000000 | addr, 1-cycle latency.
    logic [DW-1:0]      mem [128];
    logic [127:0]       mem_wr = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr_en) begin
                mem[ram_addr]    <= ram_din;
                mem_wr[ram_addr] <= 1'b1;
            end else begin
                ram_dout <= mem_wr[ram_addr] ? mem[ram_addr] : (32'hA000_0000 | 32'(ram_addr));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic v, input int idx, input logic way, input int txn);
        rd_vld = v; rd_index = IW'(idx); rd_way = way; rd_txnid = TW'(txn);
    endtask

    task automatic set_lf(input logic v, input int idx, input logic way, input int txn, input logic [DW-1:0] d);
        lf_vld = v; lf_index = IW'(idx); lf_way = way; lf_txnid = TW'(txn); lf_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_rd(1'b1, 2, 1'b0, 1);
        set_lf(1'b0, 0, 1'b0, 0, '0);
        #1;
        checks++; if (rd_rdy !== 1'b0)    begin errors++; $display("FAIL rst_rd_rdy: got %0b want 0", rd_rdy); end
        checks++; if (ram_en !== 1'b0)    begin errors++; $display("FAIL rst_ram_en: got %0b want 0", ram_en); end
        checks++; if (lf_commit !== 1'b0) begin errors++; $display("FAIL rst_lf_commit: got %0b want 0", lf_commit); end
        step();
        step();
        rst = 1'b0;
        set_rd(1'b0, 0, 1'b0, 0);
        #1;
        checks++; if (lf_rdy !== 1'b1)  begin errors++; $display("FAIL rst_lf_rdy: got %0b want 1", lf_rdy); end
        checks++; if (up_vld !== 1'b0)  begin errors++; $display("FAIL rst_up_vld: got %0b want 0", up_vld); end
        checks++; if (up_data !== '0)   begin errors++; $display("FAIL rst_up_data: got %0h want 0", up_data); end
        checks++; if (up_txnid !== '0)  begin errors++; $display("FAIL rst_up_txnid: got %0h want 0", up_txnid); end
    endtask

    task automatic test_read();
        set_rd(1'b1, 5, 1'b1, 3);
        #1;
        checks++; if (rd_rdy !== 1'b1)    begin errors++; $display("FAIL rd_rdy: got %0b want 1", rd_rdy); end
        checks++; if (ram_en !== 1'b1 || ram_wr_en !== 1'b0) begin errors++; $display("FAIL rd_ram_ctl: got en=%0b wr=%0b want en=1 wr=0", ram_en, ram_wr_en); end
        checks++; if (ram_addr !== 7'h0B) begin errors++; $display("FAIL rd_ram_addr: got %0h want 0b", ram_addr); end
        checks++; if (ram_din !== '0)     begin errors++; $display("FAIL rd_ram_din: got %0h want 0", ram_din); end
        step();
        set_rd(1'b0, 0, 1'b0, 0);
        #1;
        checks++; if (up_vld !== 1'b1 || up_txnid !== 4'd3) begin errors++; $display("FAIL rd_up_vld_txn: got vld=%0b txn=%0h want vld=1 txn=3", up_vld, up_txnid); end
        checks++; if (up_data !== 32'hA000_000B) begin errors++; $display("FAIL rd_up_data: got %0h want a000000b", up_data); end
        step();
        checks++; if (up_vld !== 1'b0 || up_data !== '0 || up_txnid !== '0) begin errors++; $display("FAIL rd_up_idle: got vld=%0b data=%0h txn=%0h want all 0", up_vld, up_data, up_txnid); end
    endtask

    task automatic test_linefill();
        set_lf(1'b1, 3, 1'b0, 7, 32'hDEAD_BEEF);
        #1;
        checks++; if (lf_rdy !== 1'b1 || ram_en !== 1'b0) begin errors++; $display("FAIL lf_accept: got rdy=%0b en=%0b want rdy=1 en=0", lf_rdy, ram_en); end
        step();
        set_lf(1'b0, 0, 1'b0, 0, '0);
        #1;
        checks++; if (ram_en !== 1'b1 || ram_wr_en !== 1'b1) begin errors++; $display("FAIL lf_wr_ctl: got en=%0b wr=%0b want 1 1", ram_en, ram_wr_en); end
        checks++; if (ram_addr !== 7'h06 || ram_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lf_wr_addr_din: got %0h/%0h want 06/deadbeef", ram_addr, ram_din); end
        checks++; if (lf_commit !== 1'b1 || lf_commit_txnid !== 4'd7) begin errors++; $display("FAIL lf_commit: got %0b/%0h want 1/7", lf_commit, lf_commit_txnid); end
        step();
        checks++; if (up_vld !== 1'b1 || up_data !== 32'hDEAD_BEEF || up_txnid !== 4'd7) begin errors++; $display("FAIL lf_up_return: got %0b/%0h/%0h want 1/deadbeef/7", up_vld, up_data, up_txnid); end
        checks++; if (lf_commit !== 1'b0) begin errors++; $display("FAIL lf_commit_pulse: got %0b want 0", lf_commit); end
    endtask

    task automatic test_starve();
        int nrd = 0;
        set_rd(1'b1, 20, 1'b0, 1);
        set_lf(1'b1, 21, 1'b1, 9, 32'h1111_2222);
        #1;
        checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL starve_first_rd: got %0b want 1", rd_rdy); end
        step();
        set_lf(1'b0, 0, 1'b0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rd_rdy === 1'b1 && ram_wr_en === 1'b0) nrd++;
            step();
        end
        checks++; if (nrd != 4) begin errors++; $display("FAIL starve_read_grants: got %0d want 4", nrd); end
        #1;
        checks++; if (rd_rdy !== 1'b0 || ram_wr_en !== 1'b1) begin errors++; $display("FAIL starve_forced_wr: got rdy=%0b wr=%0b want 0 1", rd_rdy, ram_wr_en); end
        checks++; if (lf_commit_txnid !== 4'd9) begin errors++; $display("FAIL starve_commit_txn: got %0h want 9", lf_commit_txnid); end
        step();
        checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL starve_rd_resume: got %0b want 1", rd_rdy); end
        checks++; if (up_vld !== 1'b1 || up_data !== 32'h1111_2222 || up_txnid !== 4'd9) begin errors++; $display("FAIL starve_up_return: got %0b/%0h/%0h want 1/11112222/9", up_vld, up_data, up_txnid); end
        set_rd(1'b0, 0, 1'b0, 0);
        step();
    endtask

    task automatic test_hazard();
        set_rd(1'b1, 40, 1'b0, 4);
        set_lf(1'b1, 9, 1'b0, 5, 32'hCAFE_F00D);
        #1;
        checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL haz_pre_rd: got %0b want 1", rd_rdy); end
        step();
        set_lf(1'b0, 0, 1'b0, 0, '0);
        set_rd(1'b1, 9, 1'b0, 2);
        #1;
        checks++; if (rd_rdy !== 1'b0 || ram_wr_en !== 1'b1) begin errors++; $display("FAIL haz_block: got rdy=%0b wr=%0b want 0 1", rd_rdy, ram_wr_en); end
        checks++; if (ram_addr !== 7'h12 || lf_commit_txnid !== 4'd5) begin errors++; $display("FAIL haz_wr_addr: got %0h/%0h want 12/5", ram_addr, lf_commit_txnid); end
        checks++; if (up_data !== 32'hA000_0050 || up_txnid !== 4'd4) begin errors++; $display("FAIL haz_prev_rd_data: got %0h/%0h want a0000050/4", up_data, up_txnid); end
        step();
        checks++; if (rd_rdy !== 1'b1 || ram_addr !== 7'h12) begin errors++; $display("FAIL haz_rd_after: got rdy=%0b addr=%0h want 1 12", rd_rdy, ram_addr); end
        checks++; if (up_data !== 32'hCAFE_F00D || up_txnid !== 4'd5) begin errors++; $display("FAIL haz_wr_return: got %0h/%0h want cafef00d/5", up_data, up_txnid); end
        step();
        set_rd(1'b0, 0, 1'b0, 0);
        checks++; if (up_vld !== 1'b1 || up_data !== 32'hCAFE_F00D || up_txnid !== 4'd2) begin errors++; $display("FAIL haz_new_data: got %0b/%0h/%0h want 1/cafef00d/2", up_vld, up_data, up_txnid); end
        step();
    endtask

    task automatic test_back_to_back();
        set_rd(1'b1, 50, 1'b0, 6);
        set_lf(1'b1, 10, 1'b1, 1, 32'h0000_0101);
        #1;
        checks++; if (lf_rdy !== 1'b1) begin errors++; $display("FAIL b2b_lf_rdy_a: got %0b want 1", lf_rdy); end
        step();
        set_lf(1'b1, 11, 1'b1, 2, 32'h0000_0202);
        #1;
        checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rd_b: got %0b want 1", rd_rdy); end
        step();
        set_lf(1'b1, 12, 1'b1, 3, 32'h0000_0303);
        #1;
        checks++; if (lf_rdy !== 1'b0 || rd_rdy !== 1'b0) begin errors++; $display("FAIL b2b_full: got lf_rdy=%0b rd_rdy=%0b want 0 0", lf_rdy, rd_rdy); end
        checks++; if (lf_commit !== 1'b1 || lf_commit_txnid !== 4'd1 || ram_din !== 32'h0000_0101) begin errors++; $display("FAIL b2b_commit1: got %0b/%0h/%0h want 1/1/101", lf_commit, lf_commit_txnid, ram_din); end
        step();
        #1;
        checks++; if (lf_rdy !== 1'b1 || rd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_d: got lf_rdy=%0b rd_rdy=%0b want 1 1", lf_rdy, rd_rdy); end
        step();
        set_lf(1'b0, 0, 1'b0, 0, '0);
        #1;
        checks++; if (lf_rdy !== 1'b0 || lf_commit_txnid !== 4'd2 || ram_din !== 32'h0000_0202) begin errors++; $display("FAIL b2b_commit2: got rdy=%0b txn=%0h din=%0h want 0/2/202", lf_rdy, lf_commit_txnid, ram_din); end
        step();
        set_rd(1'b0, 0, 1'b0, 0);
        #1;
        checks++; if (lf_commit_txnid !== 4'd3 || ram_addr !== 7'h19 || ram_din !== 32'h0000_0303) begin errors++; $display("FAIL b2b_commit3: got txn=%0h addr=%0h din=%0h want 3/19/303", lf_commit_txnid, ram_addr, ram_din); end
        step();
        checks++; if (ram_en !== 1'b0 || lf_rdy !== 1'b1) begin errors++; $display("FAIL b2b_drained: got en=%0b lf_rdy=%0b want 0 1", ram_en, lf_rdy); end
    endtask

    task automatic test_reset_mid();
        set_rd(1'b1, 60, 1'b0, 8);
        set_lf(1'b1, 1, 1'b0, 10, 32'h0000_AAAA);
        #1;
        checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL rmid_rd_a: got %0b want 1", rd_rdy); end
        step();
        set_lf(1'b1, 2, 1'b0, 11, 32'h0000_BBBB);
        #1;
        checks++; if (rd_rdy !== 1'b1) begin errors++; $display("FAIL rmid_rd_b: got %0b want 1", rd_rdy); end
        step();
        rst = 1'b1;
        set_lf(1'b0, 0, 1'b0, 0, '0);
        #1;
        checks++; if (rd_rdy !== 1'b0 || ram_en !== 1'b0 || lf_commit !== 1'b0) begin errors++; $display("FAIL rmid_in_rst: got rdy=%0b en=%0b commit=%0b want 0 0 0", rd_rdy, ram_en, lf_commit); end
        checks++; if (up_vld !== 1'b1) begin errors++; $display("FAIL rmid_prior_return: got %0b want 1", up_vld); end
        step();
        rst = 1'b0;
        set_rd(1'b0, 0, 1'b0, 0);
        #1;
        checks++; if (up_vld !== 1'b0 || up_data !== '0) begin errors++; $display("FAIL rmid_suppress: got vld=%0b data=%0h want 0 0", up_vld, up_data); end
        checks++; if (lf_rdy !== 1'b1 || ram_en !== 1'b0) begin errors++; $display("FAIL rmid_flushed: got lf_rdy=%0b en=%0b want 1 0", lf_rdy, ram_en); end
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_linefill();
        test_starve();
        test_hazard();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
